// File: rtl/nios2_oci_dct_pkg.sv
// rtl/nios2_oci_dct_pkg.sv - shared types and constants for the OCI DCT trace-frame scheduler
package nios2_oci_dct_pkg;

    localparam int FRAME_DATA_W = 34;
    localparam int DCT_BUF_W    = 30;

    typedef enum logic [2:0] {
        ST_ACCUM,
        ST_FLUSH_DCT,
        ST_SEND_IND,
        ST_SEND_END,
        ST_ENDED
    } sched_state_t;

    localparam logic [1:0] FT_NONE = 2'b00;
    localparam logic [1:0] FT_DCT  = 2'b01;
    localparam logic [1:0] FT_IND  = 2'b10;
    localparam logic [1:0] FT_END  = 2'b11;

    function automatic logic [FRAME_DATA_W-1:0] dct_frame(input logic [3:0] cnt,
                                                          input logic [DCT_BUF_W-1:0] dbuf);
        return {cnt, dbuf};
    endfunction

    function automatic logic [FRAME_DATA_W-1:0] ind_frame(input logic [31:0] addr);
        return {2'b00, addr};
    endfunction

endpackage

// File: rtl/nios2_oci_dct_packer.sv
// rtl/nios2_oci_dct_packer.sv - 2-bit DCT record shift buffer and record counter
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
#(
    parameter int DCT_DEPTH = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 append,
    input  logic                 clear,
    input  logic [1:0]           code,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [3:0]           dct_count,
    output logic [DCT_BUF_W-1:0] buf_next,
    output logic [3:0]           count_next
);

    // Bits above 2*DCT_DEPTH are masked so they never hold stale records.
    localparam logic [DCT_BUF_W:0]   MASK_W = (31'd1 << (2 * DCT_DEPTH)) - 31'd1;
    localparam logic [DCT_BUF_W-1:0] MASK   = MASK_W[DCT_BUF_W-1:0];

    logic [DCT_BUF_W-1:0] dbuf_q, dbuf_d;
    logic [3:0]           cnt_q, cnt_d;

    always_comb begin
        dbuf_d = dbuf_q;
        cnt_d  = cnt_q;
        if (clear) begin
            dbuf_d = '0;
            cnt_d  = '0;
        end else if (append) begin
            dbuf_d = {dbuf_q[DCT_BUF_W-3:0], code} & MASK;
            cnt_d  = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dbuf_q <= '0;
            cnt_q  <= '0;
        end else begin
            dbuf_q <= dbuf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dct_buffer = dbuf_q;
    assign dct_count  = cnt_q;
    assign buf_next   = dbuf_d;
    assign count_next = cnt_d;

endmodule

// File: rtl/nios2_oci_dct_sched.sv
// rtl/nios2_oci_dct_sched.sv - OCI trace-frame scheduler; NIOS2_OCI_DCT_SCHED_STATS_EN enables statistics counters
module nios2_oci_dct_sched
    import nios2_oci_dct_pkg::*;
#(
    parameter int DCT_DEPTH = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dct_valid,
    input  logic [1:0]              dct_code,
    output logic                    dct_ready,
    input  logic                    ind_valid,
    input  logic [31:0]             ind_addr,
    output logic                    ind_ready,
    input  logic                    test_ending,
    output logic                    frame_valid,
    output logic [1:0]              frame_type,
    output logic [FRAME_DATA_W-1:0] frame_data,
    input  logic                    frame_ready,
    output logic [DCT_BUF_W-1:0]    dct_buffer,
    output logic [3:0]              dct_count,
    output logic                    test_has_ended,
    output logic [15:0]             frames_sent,
    output logic [15:0]             stall_cycles
);

    sched_state_t              state_q;
    logic                      ind_pend_q, end_pend_q;
    logic [31:0]               ind_addr_q;
    logic                      frame_valid_q;
    logic [1:0]                frame_type_q;
    logic [FRAME_DATA_W-1:0]   frame_data_q;
    logic                      ended_q;

    logic                      accept_ok, dct_acc, ind_acc, hs, pack_clear;
    logic [DCT_BUF_W-1:0]      buf_next;
    logic [3:0]                count_next;

    assign accept_ok  = (state_q == ST_ACCUM) && !test_ending;
    assign dct_acc    = dct_valid && accept_ok;
    assign ind_acc    = ind_valid && accept_ok;
    assign hs         = frame_valid_q && frame_ready;
    assign pack_clear = (state_q == ST_FLUSH_DCT) && hs;

    nios2_oci_dct_packer #(
        .DCT_DEPTH (DCT_DEPTH)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .append     (dct_acc),
        .clear      (pack_clear),
        .code       (dct_code),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .buf_next   (buf_next),
        .count_next (count_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_ACCUM;
            ind_pend_q    <= 1'b0;
            end_pend_q    <= 1'b0;
            ind_addr_q    <= '0;
            frame_valid_q <= 1'b0;
            frame_type_q  <= FT_NONE;
            frame_data_q  <= '0;
            ended_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (test_ending) begin
                        frame_valid_q <= 1'b1;
                        if (dct_count != 4'd0) begin
                            end_pend_q   <= 1'b1;
                            state_q      <= ST_FLUSH_DCT;
                            frame_type_q <= FT_DCT;
                            frame_data_q <= dct_frame(dct_count, dct_buffer);
                        end else begin
                            state_q      <= ST_SEND_END;
                            frame_type_q <= FT_END;
                            frame_data_q <= '0;
                        end
                    end else if (ind_acc) begin
                        // Any records packed so far (including one appended this cycle)
                        // precede the indirect target in program order.
                        ind_addr_q    <= ind_addr;
                        ind_pend_q    <= 1'b1;
                        frame_valid_q <= 1'b1;
                        if (count_next != 4'd0) begin
                            state_q      <= ST_FLUSH_DCT;
                            frame_type_q <= FT_DCT;
                            frame_data_q <= dct_frame(count_next, buf_next);
                        end else begin
                            state_q      <= ST_SEND_IND;
                            frame_type_q <= FT_IND;
                            frame_data_q <= ind_frame(ind_addr);
                        end
                    end else if (dct_acc && (count_next == 4'(DCT_DEPTH))) begin
                        state_q       <= ST_FLUSH_DCT;
                        frame_valid_q <= 1'b1;
                        frame_type_q  <= FT_DCT;
                        frame_data_q  <= dct_frame(count_next, buf_next);
                    end
                end
                ST_FLUSH_DCT: begin
                    if (hs) begin
                        if (ind_pend_q) begin
                            state_q      <= ST_SEND_IND;
                            frame_type_q <= FT_IND;
                            frame_data_q <= ind_frame(ind_addr_q);
                        end else if (end_pend_q) begin
                            state_q      <= ST_SEND_END;
                            frame_type_q <= FT_END;
                            frame_data_q <= '0;
                        end else begin
                            state_q       <= ST_ACCUM;
                            frame_valid_q <= 1'b0;
                        end
                    end
                end
                ST_SEND_IND: begin
                    if (hs) begin
                        ind_pend_q    <= 1'b0;
                        state_q       <= ST_ACCUM;
                        frame_valid_q <= 1'b0;
                    end
                end
                ST_SEND_END: begin
                    if (hs) begin
                        end_pend_q    <= 1'b0;
                        state_q       <= ST_ENDED;
                        frame_valid_q <= 1'b0;
                        ended_q       <= 1'b1;
                    end
                end
                ST_ENDED: begin
                    state_q <= ST_ENDED;
                end
                default: begin
                    state_q       <= ST_ACCUM;
                    frame_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dct_ready      = accept_ok;
    assign ind_ready      = accept_ok;
    assign frame_valid    = frame_valid_q;
    assign frame_type     = frame_type_q;
    assign frame_data     = frame_data_q;
    assign test_has_ended = ended_q;

`ifdef NIOS2_OCI_DCT_SCHED_STATS_EN
    logic [15:0] frames_sent_q, frames_sent_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        frames_sent_d = frames_sent_q;
        stall_d       = stall_q;
        if (hs && (frames_sent_q != 16'hFFFF)) begin
            frames_sent_d = frames_sent_q + 16'd1;
        end
        if (frame_valid_q && !frame_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frames_sent_q <= '0;
            stall_q       <= '0;
        end else begin
            frames_sent_q <= frames_sent_d;
            stall_q       <= stall_d;
        end
    end

    assign frames_sent  = frames_sent_q;
    assign stall_cycles = stall_q;
`else
    assign frames_sent  = '0;
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_nios2_oci_dct_sched.sv
// tb/tb_nios2_oci_dct_sched.sv - self-checking bench for nios2_oci_dct_sched (honours NIOS2_OCI_DCT_SCHED_STATS_EN)
module tb_nios2_oci_dct_sched;
    import nios2_oci_dct_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        dct_valid, ind_valid, test_ending, frame_ready;
    logic [1:0]  dct_code;
    logic [31:0] ind_addr;
    logic        dct_ready, ind_ready, frame_valid, test_has_ended;
    logic [1:0]  frame_type;
    logic [33:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [15:0] frames_sent, stall_cycles;

    logic        d4_dct_valid, d4_ind_valid, d4_test_ending, d4_frame_ready;
    logic [1:0]  d4_dct_code;
    logic [31:0] d4_ind_addr;
    logic        d4_dct_ready, d4_ind_ready, d4_frame_valid, d4_test_has_ended;
    logic [1:0]  d4_frame_type;
    logic [33:0] d4_frame_data;
    logic [29:0] d4_dct_buffer;
    logic [3:0]  d4_dct_count;
    logic [15:0] d4_frames_sent, d4_stall_cycles;

    always #5 clk = ~clk;

    nios2_oci_dct_sched #(.DCT_DEPTH(15)) dut (
        .clk(clk), .reset(reset),
        .dct_valid(dct_valid), .dct_code(dct_code), .dct_ready(dct_ready),
        .ind_valid(ind_valid), .ind_addr(ind_addr), .ind_ready(ind_ready),
        .test_ending(test_ending),
        .frame_valid(frame_valid), .frame_type(frame_type), .frame_data(frame_data),
        .frame_ready(frame_ready),
        .dct_buffer(dct_buffer), .dct_count(dct_count), .test_has_ended(test_has_ended),
        .frames_sent(frames_sent), .stall_cycles(stall_cycles)
    );

    nios2_oci_dct_sched #(.DCT_DEPTH(4)) dut4 (
        .clk(clk), .reset(reset),
        .dct_valid(d4_dct_valid), .dct_code(d4_dct_code), .dct_ready(d4_dct_ready),
        .ind_valid(d4_ind_valid), .ind_addr(d4_ind_addr), .ind_ready(d4_ind_ready),
        .test_ending(d4_test_ending),
        .frame_valid(d4_frame_valid), .frame_type(d4_frame_type), .frame_data(d4_frame_data),
        .frame_ready(d4_frame_ready),
        .dct_buffer(d4_dct_buffer), .dct_count(d4_dct_count), .test_has_ended(d4_test_has_ended),
        .frames_sent(d4_frames_sent), .stall_cycles(d4_stall_cycles)
    );

    typedef struct {
        logic [1:0]  t;
        logic [33:0] d;
    } frm_t;

    typedef struct {
        int          n;
        logic [1:0]  code;
        bit          use_ind;
        logic [31:0] addr;
        logic [3:0]  exp_cnt;
        logic [29:0] exp_buf;
    } vec_t;

    frm_t exp_q[$];
    vec_t vecs[5];
    int   errors = 0;
    int   checks = 0;
    int   pops   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sample point: negedge; scoreboard pops on every handshake seen here.
    task automatic step();
        frm_t e;
        @(negedge clk);
        if (frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 64'(frame_type), 64'hF);
            end else begin
                e = exp_q.pop_front();
                chk("frame_type", 64'(frame_type), 64'(e.t));
                chk("frame_data", 64'(frame_data), 64'(e.d));
                pops++;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int f;
        bit done;
        vecs[0] = '{15, 2'b10, 1'b0, 32'h0,         4'hF, 30'h2AAAAAAA};
        vecs[1] = '{3,  2'b01, 1'b1, 32'h0000_1234, 4'h3, 30'h15};
        vecs[2] = '{5,  2'b11, 1'b1, 32'hDEAD_BEEF, 4'h5, 30'h3FF};
        vecs[3] = '{0,  2'b00, 1'b1, 32'hCAFE_0000, 4'h0, 30'h0};
        vecs[4] = '{7,  2'b00, 1'b1, 32'h0000_0001, 4'h7, 30'h0};

        reset = 1'b1; dct_valid = 0; dct_code = 0; ind_valid = 0; ind_addr = 0;
        test_ending = 0; frame_ready = 1;
        d4_dct_valid = 0; d4_dct_code = 0; d4_ind_valid = 0; d4_ind_addr = 0;
        d4_test_ending = 0; d4_frame_ready = 1;
        adv(); adv(); adv();
        reset = 1'b0;

        step();
        chk("rst_frame_valid", 64'(frame_valid), 0);
        chk("rst_frame_type", 64'(frame_type), 0);
        chk("rst_frame_data", 64'(frame_data), 0);
        chk("rst_dct_count", 64'(dct_count), 0);
        chk("rst_dct_buffer", 64'(dct_buffer), 0);
        chk("rst_test_has_ended", 64'(test_has_ended), 0);
        chk("rst_dct_ready", 64'(dct_ready), 1);
        chk("rst_ind_ready", 64'(ind_ready), 1);
        chk("rst_frames_sent", 64'(frames_sent), 0);
        chk("rst_stall_cycles", 64'(stall_cycles), 0);
        chk("d4_rst_dct_ready", 64'(d4_dct_ready), 1);
        chk("d4_rst_ind_ready", 64'(d4_ind_ready), 1);
        chk("d4_rst_ended", 64'(d4_test_has_ended), 0);
        adv();

        // Depth-4 instance: automatic flush after 4 records, upper bits stay clear.
        d4_dct_valid = 1; d4_dct_code = 2'b11;
        for (int j = 0; j < 3; j++) begin
            step(); adv();
        end
        step();
        chk("d4_count3", 64'(d4_dct_count), 3);
        chk("d4_buf3", 64'(d4_dct_buffer), 64'h3F);
        adv();
        d4_dct_valid = 0;
        step();
        chk("d4_flush_valid", 64'(d4_frame_valid), 1);
        chk("d4_flush_type", 64'(d4_frame_type), 64'(FT_DCT));
        chk("d4_flush_data", 64'(d4_frame_data), 64'({4'h4, 30'hFF}));
        chk("d4_buf_upper_zero", 64'(d4_dct_buffer[29:8]), 0);
        adv();
        step();
        chk("d4_count_cleared", 64'(d4_dct_count), 0);
        chk("d4_valid_low", 64'(d4_frame_valid), 0);
`ifdef NIOS2_OCI_DCT_SCHED_STATS_EN
        chk("d4_frames_sent", 64'(d4_frames_sent), 1);
`else
        chk("d4_frames_sent", 64'(d4_frames_sent), 0);
`endif
        chk("d4_stall_cycles", 64'(d4_stall_cycles), 0);
        adv();

        for (int v = 0; v < 5; v++) begin
            f = ((vecs[v].exp_cnt != 0) ? 1 : 0) + (vecs[v].use_ind ? 1 : 0);
            if (vecs[v].exp_cnt != 0) exp_q.push_back('{FT_DCT, {vecs[v].exp_cnt, vecs[v].exp_buf}});
            if (vecs[v].use_ind) exp_q.push_back('{FT_IND, {2'b00, vecs[v].addr}});
            for (int j = 0; j < vecs[v].n; j++) begin
                dct_valid = 1; dct_code = vecs[v].code;
                step(); adv();
            end
            dct_valid = 0;
            if (vecs[v].use_ind) begin
                ind_valid = 1; ind_addr = vecs[v].addr;
                step(); adv();
                ind_valid = 0;
            end
            step();
            chk($sformatf("v%0d_ready_low", v), 64'(dct_ready), 0);
            chk($sformatf("v%0d_first_type", v), 64'(frame_type),
                64'((vecs[v].exp_cnt != 0) ? FT_DCT : FT_IND));
            adv();
            if (f == 2) begin
                step();
                chk($sformatf("v%0d_second_type", v), 64'(frame_type), 64'(FT_IND));
                adv();
            end
            step();
            chk($sformatf("v%0d_ready_back", v), 64'(dct_ready), 1);
            chk($sformatf("v%0d_count_zero", v), 64'(dct_count), 0);
            adv();
            chk($sformatf("v%0d_drained", v), 64'(exp_q.size()), 0);
        end

        // Simultaneous DCT+IND with downstream stalled for 5 cycles.
        exp_q.push_back('{FT_DCT, {4'h1, 30'h2}});
        exp_q.push_back('{FT_IND, {2'b00, 32'h0000_ABCD}});
        frame_ready = 0;
        dct_valid = 1; dct_code = 2'b10; ind_valid = 1; ind_addr = 32'h0000_ABCD;
        step(); adv();
        dct_valid = 0; ind_valid = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", 64'(frame_valid), 1);
            chk("stall_type", 64'(frame_type), 64'(FT_DCT));
            chk("stall_data", 64'(frame_data), 64'({4'h1, 30'h2}));
            adv();
        end
        frame_ready = 1;
        step(); adv();
        step(); adv();
        step();
        chk("stall_drained", 64'(exp_q.size()), 0);
        chk("stall_ready_back", 64'(dct_ready), 1);
`ifdef NIOS2_OCI_DCT_SCHED_STATS_EN
        chk("stall_cycles", 64'(stall_cycles), 5);
        chk("frames_sent", 64'(frames_sent), 64'(pops));
`else
        chk("stall_cycles", 64'(stall_cycles), 0);
        chk("frames_sent", 64'(frames_sent), 0);
`endif
        adv();

        // Reset while an IND frame is stalled.
        frame_ready = 0;
        ind_valid = 1; ind_addr = 32'h5555_AAAA;
        step(); adv();
        ind_valid = 0;
        step();
        chk("rmid_valid_before", 64'(frame_valid), 1);
        chk("rmid_type_before", 64'(frame_type), 64'(FT_IND));
        reset = 1;
        adv();
        reset = 0;
        step();
        chk("rmid_valid", 64'(frame_valid), 0);
        chk("rmid_count", 64'(dct_count), 0);
        chk("rmid_ind_ready", 64'(ind_ready), 1);
        chk("rmid_frames_sent", 64'(frames_sent), 0);
        chk("rmid_stall", 64'(stall_cycles), 0);
        pops = 0;
        frame_ready = 1;
        adv();

        // End of test with two records pending.
        exp_q.push_back('{FT_DCT, {4'h2, 30'h5}});
        exp_q.push_back('{FT_END, 34'h0});
        dct_valid = 1; dct_code = 2'b01;
        step(); adv();
        step(); adv();
        dct_valid = 0;
        test_ending = 1;
        step();
        chk("end_ready_gated", 64'(dct_ready), 0);
        adv();
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            step();
            if (test_has_ended) done = 1;
            else adv();
        end
        chk("end_has_ended", 64'(test_has_ended), 1);
        chk("end_valid_low", 64'(frame_valid), 0);
        chk("end_drained", 64'(exp_q.size()), 0);
        adv();
        test_ending = 0;
        dct_valid = 1; ind_valid = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("ended_dct_ready", 64'(dct_ready), 0);
            chk("ended_ind_ready", 64'(ind_ready), 0);
            chk("ended_count", 64'(dct_count), 0);
            adv();
        end
        dct_valid = 0; ind_valid = 0;
        step();
        chk("final_queue", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
